// File: rtl/tour_solver_pkg.sv
// rtl/tour_solver_pkg.sv - move type, knight offsets and FSM states for tour_solver
package tour_pkg;

   typedef logic [7:0] move_t;

   // Bit b of a move_t selects offset (DX[b], DY[b])
   localparam logic signed [2:0] DX [8] = '{3'sd1, -3'sd1, -3'sd2, -3'sd2, -3'sd1, 3'sd1, 3'sd2, 3'sd2};
   localparam logic signed [2:0] DY [8] = '{3'sd2, 3'sd2, 3'sd1, -3'sd1, -3'sd2, -3'sd2, -3'sd1, 3'sd1};

   typedef enum logic [2:0] {IDLE, INIT, CALC, MOVE, BACKUP, DONE, FAIL} tour_state_t;

   function automatic logic signed [2:0] move_dx(move_t m);
      logic signed [2:0] d;
      d = '0;
      for (int b = 0; b < 8; b++) if (m[b]) d = d | DX[b];
      return d;
   endfunction

   function automatic logic signed [2:0] move_dy(move_t m);
      logic signed [2:0] d;
      d = '0;
      for (int b = 0; b < 8; b++) if (m[b]) d = d | DY[b];
      return d;
   endfunction

endpackage

// File: rtl/tour_solver_if.sv
// rtl/tour_solver_if.sv - command, status and move read-back bundle of tour_solver
interface tour_solver_if #(parameter int BOARD = 5);
   import tour_pkg::*;

   localparam int W      = $clog2(BOARD);
   localparam int NUM_MV = BOARD * BOARD - 1;
   localparam int MW     = $clog2(NUM_MV);

   logic          go;
   logic [W-1:0]  x_start;
   logic [W-1:0]  y_start;
   logic [MW-1:0] mv_indx;
   move_t         move;
   logic          busy;
   logic          done;
   logic          fail;

   modport master (output go, x_start, y_start, mv_indx, input move, busy, done, fail);
   modport slave  (input go, x_start, y_start, mv_indx, output move, busy, done, fail);

endinterface

// File: rtl/tour_solver_mask.sv
// rtl/tour_solver_mask.sv - knight_move_mask: legal, unvisited knight moves from (x,y)
module knight_move_mask
   import tour_pkg::*;
#(
   parameter int BOARD = 5,
   localparam int W  = $clog2(BOARD),
   localparam int SQ = BOARD * BOARD,
   localparam int IW = $clog2(SQ)
) (
   input  logic [W-1:0]  x,
   input  logic [W-1:0]  y,
   input  logic [SQ-1:0] visited,
   output move_t         mask
);

   int            w_nx;
   int            w_ny;
   logic [IW-1:0] w_idx;

   // Targets are formed in full integer width so an off-board target never aliases onto the board
   always_comb begin
      mask  = '0;
      w_nx  = 0;
      w_ny  = 0;
      w_idx = '0;
      for (int b = 0; b < 8; b++) begin
         w_nx = int'(x) + int'(DX[b]);
         w_ny = int'(y) + int'(DY[b]);
         if (w_nx >= 0 && w_nx < BOARD && w_ny >= 0 && w_ny < BOARD) begin
            w_idx   = IW'(w_ny * BOARD + w_nx);
            mask[b] = ~visited[w_idx];
         end
      end
   end

endmodule

// File: rtl/tour_solver.sv
// rtl/tour_solver.sv - depth-first backtracking knight's-tour search on a BOARD x BOARD grid
module tour_solver
   import tour_pkg::*;
#(
   parameter int BOARD = 5
) (
   input  logic    clk,
   input  logic    rst,
   tour_solver_if.slave bus
);

   localparam int W      = $clog2(BOARD);
   localparam int NUM_MV = BOARD * BOARD - 1;
   localparam int SQ     = BOARD * BOARD;
   localparam int IW     = $clog2(SQ);
   localparam int LW     = $clog2(NUM_MV + 1);

   tour_state_t   r_state;
   tour_state_t   w_next;
   logic [SQ-1:0] r_visited;
   logic [W-1:0]  r_x;
   logic [W-1:0]  r_y;
   logic [LW-1:0] r_lvl;
   move_t         r_poss [NUM_MV];
   move_t         r_mv   [NUM_MV];
   logic          r_busy;
   logic          r_done;
   logic          r_fail;

   move_t         w_mask;
   move_t         w_cur;
   move_t         w_pick;
   move_t         w_back;
   logic [LW-1:0] w_li;
   logic [LW-1:0] w_bi;
   logic [W-1:0]  w_nx;
   logic [W-1:0]  w_ny;
   logic [W-1:0]  w_bx;
   logic [W-1:0]  w_by;
   logic          w_start_ok;

   function automatic logic [IW-1:0] sq(logic [W-1:0] xx, logic [W-1:0] yy);
      return IW'(int'(yy) * BOARD + int'(xx));
   endfunction

   knight_move_mask #(.BOARD(BOARD)) u_mask (
      .x       (r_x),
      .y       (r_y),
      .visited (r_visited),
      .mask    (w_mask)
   );

   assign w_start_ok = (int'(bus.x_start) < BOARD) && (int'(bus.y_start) < BOARD);
   assign w_li       = (int'(r_lvl) < NUM_MV) ? r_lvl : '0;
   assign w_bi       = (r_lvl == '0) ? '0 : r_lvl - 1'b1;
   assign w_cur      = r_poss[w_li];
   assign w_pick     = w_cur & (~w_cur + 8'd1);
   assign w_back     = r_mv[w_bi];

   // Modular W-bit arithmetic is exact here: the mask only admits on-board targets
   assign w_nx = r_x + W'(move_dx(w_pick));
   assign w_ny = r_y + W'(move_dy(w_pick));
   assign w_bx = r_x - W'(move_dx(w_back));
   assign w_by = r_y - W'(move_dy(w_back));

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (bus.go) w_next = w_start_ok ? INIT : FAIL;
         INIT:    w_next = CALC;
         CALC:    w_next = MOVE;
         MOVE: begin
            if (w_cur == '0)                   w_next = BACKUP;
            else if (int'(r_lvl) + 1 == NUM_MV) w_next = DONE;
            else                               w_next = CALC;
         end
         BACKUP:  w_next = (r_lvl == '0) ? FAIL : MOVE;
         DONE:    w_next = IDLE;
         FAIL:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_fail    <= 1'b0;
         r_x       <= '0;
         r_y       <= '0;
         r_lvl     <= '0;
         r_visited <= '0;
         for (int i = 0; i < NUM_MV; i++) begin
            r_poss[i] <= '0;
            r_mv[i]   <= '0;
         end
      end else begin
         case (r_state)
            IDLE: if (bus.go) begin
               r_busy <= 1'b1;
               r_done <= 1'b0;
               r_fail <= 1'b0;
               if (w_start_ok) begin
                  r_x <= bus.x_start;
                  r_y <= bus.y_start;
               end
            end
            INIT: begin
               r_visited <= {{(SQ-1){1'b0}}, 1'b1} << sq(r_x, r_y);
               r_lvl     <= '0;
            end
            CALC: r_poss[w_li] <= w_mask;
            MOVE: if (w_cur != '0) begin
               r_mv[w_li]               <= w_pick;
               r_poss[w_li]             <= w_cur & ~w_pick;
               r_x                      <= w_nx;
               r_y                      <= w_ny;
               r_visited[sq(w_nx, w_ny)] <= 1'b1;
               r_lvl                    <= r_lvl + 1'b1;
            end
            // The level below keeps its remaining poss, so MOVE resumes at its next untried bit
            BACKUP: if (r_lvl != '0) begin
               r_visited[sq(r_x, r_y)] <= 1'b0;
               r_x                     <= w_bx;
               r_y                     <= w_by;
               r_lvl                   <= r_lvl - 1'b1;
            end
            DONE: begin
               r_done <= 1'b1;
               r_busy <= 1'b0;
            end
            FAIL: begin
               r_fail <= 1'b1;
               r_busy <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign bus.fail = r_fail;
   assign bus.move = (int'(bus.mv_indx) < NUM_MV) ? r_mv[bus.mv_indx] : 8'h00;

endmodule

// File: tb/tb_tour_solver.sv
// tb/tb_tour_solver.sv - scoreboard bench for tour_solver on 5x5 and 3x3 boards
module tb_tour_solver;
   import tour_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   tour_solver_if #(.BOARD(5)) if5 ();
   tour_solver_if #(.BOARD(3)) if3 ();

   tour_solver #(.BOARD(5)) dut5 (.clk(clk), .rst(rst), .bus(if5));
   tour_solver #(.BOARD(3)) dut3 (.clk(clk), .rst(rst), .bus(if3));

   typedef struct {
      logic done;
      logic fail;
      int   cycles;
   } exp_t;

   int     checks = 0;
   int     errors = 0;
   exp_t   exp_q[$];
   move_t  exp_mv_q[$];
   int     cyc_cnt = 0;
   int     go_cyc = 0;
   int     KDX [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
   int     KDY [8] = '{2, 2, 1, -1, -2, -2, -1, 1};
   bit     mvis [64];
   move_t  m_mv [64];
   move_t  m_poss [64];

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   function automatic int bit_of(move_t m);
      for (int b = 0; b < 8; b++) if (m[b]) return b;
      return 0;
   endfunction

   function automatic move_t model_mask(int n, int x, int y);
      move_t r;
      int nx, ny;
      r = '0;
      for (int b = 0; b < 8; b++) begin
         nx = x + KDX[b];
         ny = y + KDY[b];
         if (nx >= 0 && nx < n && ny >= 0 && ny < n && !mvis[ny * n + nx]) r[b] = 1'b1;
      end
      return r;
   endfunction

   // Reference search: produces the move list, the outcome and the cycle count from go to done/fail
   task automatic model_run(input int n, input int sx, input int sy, output bit ok, output int cyc);
      int x, y, lvl, nm, b;
      bit fin;
      move_t p, one;
      one = 8'h01;
      nm  = n * n - 1;
      for (int i = 0; i < 64; i++) mvis[i] = 1'b0;
      x = sx; y = sy; lvl = 0; ok = 0; fin = 0;
      mvis[y * n + x] = 1'b1;
      cyc = 2;
      m_poss[0] = model_mask(n, x, y);
      while (!fin) begin
         cyc++;
         p = m_poss[lvl];
         if (p == '0) begin
            cyc++;
            if (lvl == 0) begin
               cyc++;
               fin = 1;
            end else begin
               mvis[y * n + x] = 1'b0;
               b = bit_of(m_mv[lvl - 1]);
               x -= KDX[b];
               y -= KDY[b];
               lvl--;
            end
         end else begin
            b = bit_of(p);
            m_mv[lvl] = one << b;
            m_poss[lvl][b] = 1'b0;
            x += KDX[b];
            y += KDY[b];
            mvis[y * n + x] = 1'b1;
            lvl++;
            cyc++;
            if (lvl == nm) begin
               ok  = 1;
               fin = 1;
            end else begin
               m_poss[lvl] = model_mask(n, x, y);
            end
         end
      end
   endtask

   task automatic drive_go5(input int sx, input int sy, input bit push);
      bit ok;
      int cyc;
      exp_t e;
      if (push) begin
         model_run(5, sx, sy, ok, cyc);
         e.done = ok; e.fail = !ok; e.cycles = cyc;
         exp_q.push_back(e);
         if (ok) for (int i = 0; i < 24; i++) exp_mv_q.push_back(m_mv[i]);
      end
      @(negedge clk);
      if5.x_start = 3'(sx);
      if5.y_start = 3'(sy);
      if5.go = 1'b1;
      @(posedge clk);
      #1;
      go_cyc = cyc_cnt;
      if5.go = 1'b0;
   endtask

   task automatic finish_run5(input string name, input int sx, input int sy);
      exp_t e;
      move_t got, em;
      int x, y, b, bad, cnt;
      bit v [25];
      e = exp_q.pop_front();
      while (if5.busy && (cyc_cnt - go_cyc) <= e.cycles + 50) begin
         @(posedge clk);
         #1;
      end
      checks++;
      if (if5.busy !== 1'b0) begin
         errors++;
         $display("FAIL %s timeout: busy=%0b after %0d cycles, required done within %0d", name, if5.busy, cyc_cnt - go_cyc, e.cycles);
      end
      checks++;
      if ((cyc_cnt - go_cyc) !== e.cycles) begin
         errors++;
         $display("FAIL %s latency: got %0d cycles, required %0d", name, cyc_cnt - go_cyc, e.cycles);
      end
      checks++;
      if ({if5.done, if5.fail} !== {e.done, e.fail}) begin
         errors++;
         $display("FAIL %s status: done/fail got %0b%0b, required %0b%0b", name, if5.done, if5.fail, e.done, e.fail);
      end
      if (e.done) begin
         for (int i = 0; i < 25; i++) v[i] = 1'b0;
         x = sx; y = sy; bad = 0; cnt = 1;
         v[y * 5 + x] = 1'b1;
         for (int i = 0; i < 24; i++) begin
            if5.mv_indx = 5'(i);
            #1;
            got = if5.move;
            em  = exp_mv_q.pop_front();
            checks++;
            if (got !== em) begin
               errors++;
               $display("FAIL %s move[%0d]: got %02h, required %02h", name, i, got, em);
            end
            if ($countones(got) != 1) bad++;
            else begin
               b = bit_of(got);
               x += KDX[b];
               y += KDY[b];
               if (x < 0 || x > 4 || y < 0 || y > 4) bad++;
               else if (v[y * 5 + x]) bad++;
               else begin
                  v[y * 5 + x] = 1'b1;
                  cnt++;
               end
            end
         end
         checks++;
         if (bad !== 0 || cnt !== 25) begin
            errors++;
            $display("FAIL %s tour_valid: %0d bad steps, %0d squares visited, required 0 and 25", name, bad, cnt);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({if5.busy, if5.done, if5.fail} !== 3'b000) begin
         errors++;
         $display("FAIL reset5 status: busy/done/fail got %03b, required 000", {if5.busy, if5.done, if5.fail});
      end
      checks++;
      if ({if3.busy, if3.done, if3.fail} !== 3'b000) begin
         errors++;
         $display("FAIL reset3 status: busy/done/fail got %03b, required 000", {if3.busy, if3.done, if3.fail});
      end
      for (int i = 0; i < 32; i++) begin
         if5.mv_indx = 5'(i);
         #1;
         checks++;
         if (if5.move !== 8'h00) begin
            errors++;
            $display("FAIL reset5 move[%0d]: got %02h, required 00", i, if5.move);
         end
      end
      for (int i = 0; i < 8; i++) begin
         if3.mv_indx = 3'(i);
         #1;
         checks++;
         if (if3.move !== 8'h00) begin
            errors++;
            $display("FAIL reset3 move[%0d]: got %02h, required 00", i, if3.move);
         end
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_tour_center();
      drive_go5(2, 2, 1);
      checks++;
      if ({if5.busy, if5.done, if5.fail} !== 3'b100) begin
         errors++;
         $display("FAIL center start: busy/done/fail got %03b, required 100", {if5.busy, if5.done, if5.fail});
      end
      finish_run5("center", 2, 2);
      if5.mv_indx = 5'd0;
      #1;
      checks++;
      if (if5.move !== 8'h01) begin
         errors++;
         $display("FAIL center first_move: got %02h, required 01", if5.move);
      end
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if ({if5.busy, if5.done, if5.fail} !== 3'b010) begin
         errors++;
         $display("FAIL center hold: busy/done/fail got %03b, required 010", {if5.busy, if5.done, if5.fail});
      end
      for (int i = 24; i < 32; i++) begin
         if5.mv_indx = 5'(i);
         #1;
         checks++;
         if (if5.move !== 8'h00) begin
            errors++;
            $display("FAIL center oob move[%0d]: got %02h, required 00", i, if5.move);
         end
      end
   endtask

   task automatic test_fail_3x3();
      bit ok;
      int cyc, start;
      exp_t e;
      model_run(3, 0, 0, ok, cyc);
      e.done = 1'b0; e.fail = 1'b1; e.cycles = cyc;
      exp_q.push_back(e);
      @(negedge clk);
      if3.x_start = 2'd0;
      if3.y_start = 2'd0;
      if3.go = 1'b1;
      @(posedge clk);
      #1;
      start = cyc_cnt;
      if3.go = 1'b0;
      e = exp_q.pop_front();
      while (if3.busy && (cyc_cnt - start) < 200) begin
         @(posedge clk);
         #1;
      end
      checks++;
      if (if3.busy !== 1'b0) begin
         errors++;
         $display("FAIL fail3x3 timeout: busy=%0b after 200 cycles, required 0", if3.busy);
      end
      checks++;
      if ({if3.done, if3.fail} !== {e.done, e.fail}) begin
         errors++;
         $display("FAIL fail3x3 status: done/fail got %0b%0b, required %0b%0b", if3.done, if3.fail, e.done, e.fail);
      end
      checks++;
      if ((cyc_cnt - start) !== e.cycles) begin
         errors++;
         $display("FAIL fail3x3 latency: got %0d cycles, required %0d", cyc_cnt - start, e.cycles);
      end
   endtask

   task automatic test_illegal_start();
      drive_go5(5, 0, 0);
      checks++;
      if ({if5.busy, if5.done, if5.fail} !== 3'b100) begin
         errors++;
         $display("FAIL illegal edge_k: busy/done/fail got %03b, required 100", {if5.busy, if5.done, if5.fail});
      end
      @(posedge clk);
      #1;
      checks++;
      if ({if5.busy, if5.done, if5.fail} !== 3'b001) begin
         errors++;
         $display("FAIL illegal edge_k1: busy/done/fail got %03b, required 001", {if5.busy, if5.done, if5.fail});
      end
   endtask

   task automatic test_go_while_busy();
      drive_go5(2, 2, 1);
      repeat (10) @(posedge clk);
      @(negedge clk);
      if5.x_start = 3'd0;
      if5.y_start = 3'd0;
      if5.go = 1'b1;
      @(negedge clk);
      if5.go = 1'b0;
      finish_run5("busy_go", 2, 2);
   endtask

   task automatic test_reset_mid_search();
      drive_go5(2, 2, 0);
      repeat (49) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if ({if5.busy, if5.done, if5.fail} !== 3'b000) begin
         errors++;
         $display("FAIL midrst status: busy/done/fail got %03b, required 000", {if5.busy, if5.done, if5.fail});
      end
      for (int i = 0; i < 24; i += 6) begin
         if5.mv_indx = 5'(i);
         #1;
         checks++;
         if (if5.move !== 8'h00) begin
            errors++;
            $display("FAIL midrst move[%0d]: got %02h, required 00", i, if5.move);
         end
      end
      @(negedge clk);
      rst = 1'b0;
      drive_go5(0, 0, 1);
      finish_run5("corner", 0, 0);
   endtask

   initial begin
      rst = 1'b1;
      if5.go = 1'b0; if5.x_start = '0; if5.y_start = '0; if5.mv_indx = '0;
      if3.go = 1'b0; if3.x_start = '0; if3.y_start = '0; if3.mv_indx = '0;
      test_reset();
      test_tour_center();
      test_fail_3x3();
      test_illegal_start();
      test_go_while_busy();
      test_reset_mid_search();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
